// File: rtl/ins_memory_responder_pkg.sv
// Shared types, constants and memory helper functions for the instruction
// memory responder.
package ins_memory_responder_pkg;

    // Widest bus the helpers below are written for.
    localparam int unsigned DATA_MAX_W = 64;

    // Instruction returned for an out-of-range fetch (all zeros).
    localparam logic [DATA_MAX_W-1:0] NOP_WORD = '0;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    // True when a word address falls inside a memory of num_words entries.
    function automatic logic addr_in_range(input logic [DATA_MAX_W-1:0] addr,
                                           input int unsigned num_words);
        return (addr < DATA_MAX_W'(num_words));
    endfunction

    // Word read back for a fetch: stored word when in range, NOP otherwise.
    function automatic logic [DATA_MAX_W-1:0] fetch_word(input logic in_range,
                                                         input logic [DATA_MAX_W-1:0] word);
        return in_range ? word : NOP_WORD;
    endfunction

endpackage

// File: rtl/ins_memory_responder_mem_array.sv
// Instruction storage: one synchronous write port and one synchronous read
// port. A read and write of the same word at one edge returns the old word.
module ins_mem_array
    import ins_memory_responder_pkg::*;
#(
    parameter int bus_width = 32,
    parameter int depth     = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [bus_width-1:0] wr_addr,
    input  logic [bus_width-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [bus_width-1:0] rd_addr,
    output logic [bus_width-1:0] rd_data
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;

    logic [bus_width-1:0] mem_r [depth];
    logic [bus_width-1:0] rd_data_r;
    logic                 wr_ok_s;
    logic                 rd_ok_s;
    logic [DATA_MAX_W-1:0] rd_word_s;

    // Range decode and NOP substitution for the read port.
    always_comb begin
        wr_ok_s   = addr_in_range(DATA_MAX_W'(wr_addr), depth);
        rd_ok_s   = addr_in_range(DATA_MAX_W'(rd_addr), depth);
        rd_word_s = NOP_WORD;
        if (rd_ok_s) begin
            rd_word_s = fetch_word(1'b1, DATA_MAX_W'(mem_r[rd_addr[AW-1:0]]));
        end else begin
            rd_word_s = fetch_word(1'b0, NOP_WORD);
        end
    end

    // Storage write; contents survive reset, out-of-range writes are dropped.
    always_ff @(posedge clock) begin
        if (wr_en && wr_ok_s) begin
            mem_r[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Read data register; only updates on a read so it holds between fetches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= rd_word_s[bus_width-1:0];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/ins_memory_responder.sv
// Instruction memory responder: accepts fetch requests, waits a fixed
// latency, then pulses valid_out with the instruction and its address.
module ins_memory_responder
    import ins_memory_responder_pkg::*;
#(
    parameter int bus_width = 32,
    parameter int depth     = 256,
    parameter int latency   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_in,
    input  logic [bus_width-1:0] addr_in,
    input  logic                 flush_in,
    input  logic                 load_en_in,
    input  logic [bus_width-1:0] load_addr_in,
    input  logic [bus_width-1:0] load_data_in,
    output logic                 ready_out,
    output logic                 valid_out,
    output logic [bus_width-1:0] ins_out,
    output logic [bus_width-1:0] addr_out,
    output logic                 error_out
);

    // Countdown reload value; zero means the response follows acceptance directly.
    localparam logic [3:0] LAT_M1 = 4'(latency - 1);

    resp_state_e          state_r, next_state_s;
    logic [3:0]           cnt_r, next_cnt_s;
    logic [bus_width-1:0] addr_r;
    logic [bus_width-1:0] rd_addr_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 resp_entry_s;
    logic                 valid_r;
    logic [bus_width-1:0] addr_out_r;
    logic                 err_r;

    // Next-state, countdown and RESP-entry decode.
    always_comb begin
        ready_s      = (state_r != WAIT);
        accept_s     = req_in && ready_s && !flush_in;
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        resp_entry_s = 1'b0;
        rd_addr_s    = addr_r;
        if (flush_in) begin
            next_state_s = IDLE;
            next_cnt_s   = 4'd0;
        end else begin
            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        next_cnt_s = LAT_M1;
                        if (LAT_M1 == 4'd0) begin
                            // Single-cycle latency: read the incoming address now.
                            next_state_s = RESP;
                            resp_entry_s = 1'b1;
                            rd_addr_s    = addr_in;
                        end else begin
                            next_state_s = WAIT;
                        end
                    end else begin
                        next_state_s = IDLE;
                        next_cnt_s   = 4'd0;
                    end
                end
                WAIT: begin
                    if (cnt_r <= 4'd1) begin
                        next_state_s = RESP;
                        next_cnt_s   = 4'd0;
                        resp_entry_s = 1'b1;
                    end else begin
                        next_state_s = WAIT;
                        next_cnt_s   = cnt_r - 4'd1;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_cnt_s   = 4'd0;
                end
            endcase
        end
    end

    // State, countdown and captured fetch address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            if (accept_s) begin
                addr_r <= addr_in;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Registered response sideband; address and error hold between responses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r    <= 1'b0;
            addr_out_r <= '0;
            err_r      <= 1'b0;
        end else begin
            valid_r <= resp_entry_s;
            if (resp_entry_s) begin
                addr_out_r <= rd_addr_s;
                err_r      <= !addr_in_range(DATA_MAX_W'(rd_addr_s), depth);
            end else begin
                addr_out_r <= addr_out_r;
                err_r      <= err_r;
            end
        end
    end

    ins_mem_array #(
        .bus_width (bus_width),
        .depth     (depth)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (load_en_in),
        .wr_addr (load_addr_in),
        .wr_data (load_data_in),
        .rd_en   (resp_entry_s),
        .rd_addr (rd_addr_s),
        .rd_data (ins_out)
    );

    assign ready_out = ready_s;
    assign valid_out = valid_r;
    assign addr_out  = addr_out_r;
    assign error_out = err_r;

endmodule

// File: tb/tb_ins_memory_responder.sv
// Scoreboard bench: three responders with latency 1, 2 and 3 (instance g has
// latency g+1), each with its own stimulus; expected responses are queued
// when a request is issued and popped by a monitor on valid_out.
module tb_ins_memory_responder;

    localparam int W = 32;

    logic clock;
    logic reset;
    logic [2:0] req, flush, ld_en;
    logic [W-1:0] addr [3];
    logic [W-1:0] ld_addr [3];
    logic [W-1:0] ld_data [3];
    logic [2:0] ready, valid, err;
    logic [W-1:0] ins [3];
    logic [W-1:0] aout [3];

    int cyc;
    int checks;
    int errors;

    typedef struct {
        int dut;
        int exp_cyc;
        logic [W-1:0] ins;
        logic [W-1:0] addr;
        logic err;
    } exp_t;

    exp_t exp_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ins_memory_responder #(
            .bus_width (W),
            .depth     (256),
            .latency   (g + 1)
        ) u_dut (
            .clock        (clock),
            .reset        (reset),
            .req_in       (req[g]),
            .addr_in      (addr[g]),
            .flush_in     (flush[g]),
            .load_en_in   (ld_en[g]),
            .load_addr_in (ld_addr[g]),
            .load_data_in (ld_data[g]),
            .ready_out    (ready[g]),
            .valid_out    (valid[g]),
            .ins_out      (ins[g]),
            .addr_out     (aout[g]),
            .error_out    (err[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: pops one expectation per valid_out pulse, flags late/missing ones.
    always @(negedge clock) begin
        for (int g = 0; g < 3; g++) begin
            if (valid[g] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid dut%0d cyc %0d: actual valid=1 required valid=0", g, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.dut != g || e.exp_cyc != cyc || ins[g] !== e.ins ||
                        aout[g] !== e.addr || err[g] !== e.err) begin
                        errors++;
                        $display("FAIL resp: actual dut%0d cyc %0d ins=%h addr=%h err=%b required dut%0d cyc %0d ins=%h addr=%h err=%b",
                                 g, cyc, ins[g], aout[g], err[g], e.dut, e.exp_cyc, e.ins, e.addr, e.err);
                    end
                end
            end
        end
        if (exp_q.size() > 0 && exp_q[0].exp_cyc < cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid dut%0d: actual no valid_out by cyc %0d required at cyc %0d", e.dut, cyc, e.exp_cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req_v);
        end
    endtask

    // Queue the response for a request presented now; it is accepted at the
    // next edge (cyc+1) and valid_out is visible after edge cyc+1+latency-1.
    task automatic push_exp(input int g, input logic [W-1:0] a, input logic [W-1:0] d, input logic e);
        exp_t x;
        x.dut = g;
        x.exp_cyc = cyc + 1 + g;
        x.ins = d;
        x.addr = a;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic load(input int g, input logic [W-1:0] a, input logic [W-1:0] d);
        ld_en[g] = 1'b1;
        ld_addr[g] = a;
        ld_data[g] = d;
        tick();
        ld_en[g] = 1'b0;
    endtask

    task automatic fetch(input int g, input logic [W-1:0] a, input logic [W-1:0] d, input logic e);
        req[g] = 1'b1;
        addr[g] = a;
        push_exp(g, a, d, e);
        tick();
        req[g] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        req = '0;
        flush = '0;
        ld_en = '0;
        for (int g = 0; g < 3; g++) begin
            addr[g] = '0;
            ld_addr[g] = '0;
            ld_data[g] = '0;
        end

        // Reset state of every instance.
        repeat (2) @(posedge clock);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_valid%0d", g), {31'd0, valid[g]}, 32'd0);
            chk($sformatf("rst_ready%0d", g), {31'd0, ready[g]}, 32'd1);
            chk($sformatf("rst_ins%0d", g), ins[g], 32'd0);
            chk($sformatf("rst_addr%0d", g), aout[g], 32'd0);
            chk($sformatf("rst_err%0d", g), {31'd0, err[g]}, 32'd0);
        end
        reset = 1'b1;
        idle(2);

        // Latency 2: load 0x11 at 4 and fetch it.
        load(1, 32'd4, 32'h11);
        fetch(1, 32'd4, 32'h11, 1'b0);
        idle(4);

        // Latency 1: back-to-back fetches of 0,1,2 with req held high.
        load(0, 32'd0, 32'hA0);
        load(0, 32'd1, 32'hA1);
        load(0, 32'd2, 32'hA2);
        req[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr[0] = 32'(i);
            push_exp(0, 32'(i), 32'hA0 + 32'(i), 1'b0);
            tick();
        end
        req[0] = 1'b0;
        idle(4);

        // Latency 3: fetch of 8 flushed one cycle later yields no response.
        req[2] = 1'b1;
        addr[2] = 32'd8;
        tick();
        req[2] = 1'b0;
        flush[2] = 1'b1;
        tick();
        flush[2] = 1'b0;
        chk("flush_ready", {31'd0, ready[2]}, 32'd1);
        idle(6);

        // Out-of-range fetch and ignored out-of-range load (300 aliases 44).
        load(1, 32'd44, 32'h44);
        load(1, 32'd300, 32'h5A);
        fetch(1, 32'd300, 32'h0, 1'b1);
        idle(4);
        fetch(1, 32'd44, 32'h44, 1'b0);
        idle(4);

        // Same-edge write and read returns the old word; next fetch sees new.
        load(0, 32'd5, 32'hAA);
        req[0] = 1'b1;
        addr[0] = 32'd5;
        ld_en[0] = 1'b1;
        ld_addr[0] = 32'd5;
        ld_data[0] = 32'hBB;
        push_exp(0, 32'd5, 32'hAA, 1'b0);
        tick();
        req[0] = 1'b0;
        ld_en[0] = 1'b0;
        idle(3);
        fetch(0, 32'd5, 32'hBB, 1'b0);
        idle(3);

        // Reset during WAIT aborts the fetch, clears outputs, keeps memory.
        load(2, 32'd9, 32'h77);
        fetch(2, 32'd9, 32'h77, 1'b0);
        idle(5);
        req[2] = 1'b1;
        addr[2] = 32'd9;
        tick();
        req[2] = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, valid[2]}, 32'd0);
        chk("midrst_ins", ins[2], 32'd0);
        chk("midrst_addr", aout[2], 32'd0);
        chk("midrst_err", {31'd0, err[2]}, 32'd0);
        chk("midrst_ready", {31'd0, ready[2]}, 32'd1);
        #1;
        reset = 1'b1;
        idle(4);
        fetch(2, 32'd9, 32'h77, 1'b0);
        idle(6);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid dut%0d: actual none required response at cyc %0d", e.dut, e.exp_cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
